// File: rtl/serial_sum_collector_pkg.sv
// -----------------------------------------------------------------------------
// serial_sum_collector_pkg
// Shared definitions for the serial sum collector:
//   - state_t       : FSM state encodings (IDLE / COLLECT / DONE)
//   - DEFAULT_WIDTH : default number of sum bits per word
// -----------------------------------------------------------------------------
package serial_sum_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_sum_collector_pkg

// File: rtl/serial_sum_collector_sipo_register.sv
// -----------------------------------------------------------------------------
// sipo_register
// WIDTH-bit serial-in parallel-out shift register. Bits enter at the MSB and
// move toward the LSB, so after WIDTH shifts the first bit sits in bit 0.
//
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous active-high reset, clears the register
//   i_clear  : synchronous clear (has priority over i_shift)
//   i_shift  : shift enable
//   i_bit    : serial input bit, enters at the MSB
//   o_q      : parallel register contents
// -----------------------------------------------------------------------------
module sipo_register
    import serial_sum_collector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_shift) begin
            r_q <= {i_bit, r_q[WIDTH-1:1]};
        end
    end

    assign o_q = r_q;

endmodule : sipo_register

// File: rtl/serial_sum_collector.sv
// -----------------------------------------------------------------------------
// serial_sum_collector
// Collects LSB-first sum bits from the bit-serial adder into a WIDTH-bit
// parallel word. A start/ack handshake brackets each word:
//   IDLE --start--> COLLECT --WIDTH accepted bits--> DONE --ack--> IDLE
//
// Handshake: i_start is honoured only in IDLE, i_enable only in COLLECT and
// i_ack only in DONE; each is sampled on a rising edge and acted on at that
// edge. Outside its state an input is ignored. o_busy/o_done are decoded from
// the state register only, never from inputs.
//
// Optional feature macro: SUM_OVERFLOW_EN
//   defined   : o_overflow port exists and captures i_carry of the final bit
//   undefined : no o_overflow port, i_carry is unused
//
// Ports:
//   i_clk       : clock, rising edge
//   i_reset     : asynchronous active-high reset
//   i_start     : begin a new word (IDLE only)
//   i_enable    : i_sum_bit valid this cycle (COLLECT only)
//   i_sum_bit   : serial sum bit, LSB first
//   i_carry     : adder carry-out for the current bit
//   i_ack       : consumer has taken o_result (DONE only)
//   o_busy      : high in COLLECT
//   o_done      : high in DONE
//   o_result    : last completed word
//   o_overflow  : carry-out of the final bit (SUM_OVERFLOW_EN only)
//   o_dbg_state : current FSM state encoding
// -----------------------------------------------------------------------------
module serial_sum_collector
    import serial_sum_collector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_enable,
    input  logic             i_sum_bit,
    input  logic             i_carry,
    input  logic             i_ack,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
`ifdef SUM_OVERFLOW_EN
    output logic             o_overflow,
`endif
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_shift_q;
    logic             w_begin;
    logic             w_accept;
    logic             w_last;

    // Qualified events; each input only counts in its own state.
    assign w_begin  = (r_state == ST_IDLE) && i_start;
    assign w_accept = (r_state == ST_COLLECT) && i_enable;
    assign w_last   = w_accept && (r_cnt == LAST_IDX);

    sipo_register #(
        .WIDTH(WIDTH)
    ) u_sipo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_begin),
        .i_shift (w_accept),
        .i_bit   (i_sum_bit),
        .o_q     (w_shift_q)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_next_state = ST_COLLECT;
            ST_COLLECT: if (w_last)  w_next_state = ST_DONE;
            ST_DONE:    if (i_ack)   w_next_state = ST_IDLE;
            default:                 w_next_state = ST_IDLE;
        endcase
    end

    // Bit counter: counts accepted bits of the current word. It only reaches
    // WIDTH-1 before the word completes, so it never wraps.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_begin) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The shift register still holds only WIDTH-1 bits at the final edge,
    // so the result is assembled from the incoming bit plus the upper bits.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_result <= '0;
        end else if (w_last) begin
            r_result <= {i_sum_bit, w_shift_q[WIDTH-1:1]};
        end
    end

`ifdef SUM_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_overflow <= i_carry;
        end
    end

    assign o_overflow = r_overflow;
`else
    logic w_unused_carry;
    assign w_unused_carry = i_carry;
`endif

    assign o_busy      = (r_state == ST_COLLECT);
    assign o_done      = (r_state == ST_DONE);
    assign o_result    = r_result;
    assign o_dbg_state = r_state;

endmodule : serial_sum_collector

// File: tb/tb_serial_sum_collector.sv
module tb_serial_sum_collector;
  import serial_sum_collector_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         enable = 1'b0;
  logic         sum_bit = 1'b0;
  logic         carry = 1'b0;
  logic         ack = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;
`ifdef SUM_OVERFLOW_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // scoreboard of expected completed words
  logic [W-1:0] exp_q[$];

  serial_sum_collector #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_enable    (enable),
    .i_sum_bit   (sum_bit),
    .i_carry     (carry),
    .i_ack       (ack),
    .o_busy      (busy),
    .o_done      (done),
    .o_result    (result),
`ifdef SUM_OVERFLOW_EN
    .o_overflow  (overflow),
`endif
    .o_dbg_state (dbg_state)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one active edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_result"}, 32'(result), 32'd0);
    check_val({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
`ifdef SUM_OVERFLOW_EN
    check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
`endif
  endtask

  // Drive one word: start edge, then W accepted bits. With gaps, every other
  // cycle after the start edge carries enable=0 and garbage data.
  task automatic send_word(input string tag, input logic [W-1:0] data,
                           input logic [W-1:0] carries, input bit gaps);
    int idx;
    int edges;
    start = 1'b1; enable = 1'b1; sum_bit = 1'b1; carry = 1'b1;  // enable ignored in IDLE
    tick();
    start = 1'b0;
    check_val({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    idx = 0;
    edges = 0;
    while (idx < W) begin
      if (gaps && (edges % 2 == 0)) begin
        enable = 1'b0;
        sum_bit = 1'($urandom_range(0, 1));
        carry = 1'($urandom_range(0, 1));
      end else begin
        enable = 1'b1;
        sum_bit = data[idx];
        carry = carries[idx];
        idx++;
      end
      check_val($sformatf("%s_no_early_done_e%0d", tag, edges), 32'(done), 32'd0);
      tick();
      edges++;
    end
    enable = 1'b0; sum_bit = 1'b0; carry = 1'b0;
    check_val({tag, "_edges"}, 32'(edges), gaps ? 32'(2 * W) : 32'(W));
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_busy_low"}, 32'(busy), 32'd0);
    exp_q.push_back(data);
    check_val({tag, "_result"}, 32'(result), 32'(exp_q.pop_front()));
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val({tag, "_done_low"}, 32'(done), 32'd0);
    check_val({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    // reset state
    #3;
    check_cleared("por");
    tick();
    reset = 1'b0;
    tick();
    check_cleared("post_reset");

    // A5 with enable held high
    send_word("a5", 8'hA5, 8'h00, 1'b0);
    do_ack("a5_ack");

    // 3C with gaps
    send_word("3c", 8'h3C, 8'h00, 1'b1);
    check_val("3c_result_hold_before_ack", 32'(result), 32'h3C);
    do_ack("3c_ack");
    check_val("3c_result_hold_idle", 32'(result), 32'h3C);

`ifdef SUM_OVERFLOW_EN
    send_word("ovf1", 8'h5A, 8'h80, 1'b0);
    check_val("ovf1_overflow", 32'(overflow), 32'd1);
    do_ack("ovf1_ack");
    check_val("ovf1_hold", 32'(overflow), 32'd1);
    send_word("ovf0", 8'h0F, 8'h7F, 1'b0);
    check_val("ovf0_overflow", 32'(overflow), 32'd0);
    do_ack("ovf0_ack");
`endif

    // reset after 4 bits of a word
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1;
      sum_bit = 1'b1;
      tick();
    end
    enable = 1'b0;
    check_val("mid_busy_before_rst", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("mid_rst");
    tick();
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_cleared("idle_10");

    // full word after reset
    send_word("ff", 8'hFF, 8'h00, 1'b0);

    // DONE holds while ack is low, regardless of other inputs
    for (int i = 0; i < 5; i++) begin
      start = 1'(i % 2);
      enable = 1'b1;
      sum_bit = 1'((i + 1) % 2);
      tick();
      check_val($sformatf("hold_done_%0d", i), 32'(done), 32'd1);
      check_val($sformatf("hold_result_%0d", i), 32'(result), 32'hFF);
    end
    start = 1'b0; enable = 1'b0;

    // ack together with start: start is not honoured in DONE
    start = 1'b1;
    do_ack("ack_start");
    check_val("ack_start_busy_low", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check_val("restart_busy", 32'(busy), 32'd1);
    check_val("restart_result_hold", 32'(result), 32'hFF);

    // second word immediately via restart path: partial word then reset
    #2;
    reset = 1'b1;
    #1;
    check_cleared("final_rst");
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_sum_collector

// File: doc/serial_sum_collector.md
# serial_sum_collector

Serial-to-parallel result collector at the output end of the bit-serial adder datapath. Accepts sum bits LSB-first, one per enabled clock edge, assembles them into a WIDTH-bit parallel word, and raises `done` once the word is complete. A start/ack handshake brackets each word. It is the receiving counterpart of the operand shift-out path that feeds the adder.

## Interface
- `WIDTH`, 8, number of sum bits per word; must be ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new word; honoured only in IDLE.
- `enable`  in  1  `sum_bit` is valid this cycle; honoured only in COLLECT.
- `sum_bit`  in  1  current serial sum bit, LSB first.
- `carry`  in  1  adder carry-out for the bit currently on `sum_bit`.
- `ack`  in  1  consumer has taken `result`; honoured only in DONE.
- `busy`  out  1  high in COLLECT.
- `done`  out  1  high in DONE.
- `result`  out  WIDTH  last completed word.
- `overflow`  out  1  carry-out of the final bit (present only with `SUM_OVERFLOW_EN`).

## Operation
- States: IDLE, COLLECT, DONE. Reset state is IDLE.
- IDLE, `start`=1 → COLLECT. Shift register and bit counter cleared. `enable` in the same cycle is ignored.
- COLLECT, `enable`=1 → shift register shifts right with `sum_bit` entering the MSB; counter increments.
- COLLECT, `enable`=0 → hold. Gaps of any length are legal.
- COLLECT, the edge that accepts bit WIDTH-1 (the WIDTH-th bit) → DONE. On that same edge, `result` loads the fully shifted word, so bit i of `result` is the i-th accepted bit.
- DONE, `ack`=1 → IDLE. Otherwise hold.
- `start` outside IDLE and `enable` outside COLLECT have no effect. `sum_bit`/`carry` are don't-care whenever `enable`=0.
- `result` changes only at word completion or reset. It holds its value through IDLE and the next COLLECT.
- Bit counter width is $clog2(WIDTH+1). It is never compared beyond WIDTH-1, so there is no wrap.
- Reset values: `busy`=0, `done`=0, `result`=0, `overflow`=0. Counter and shift register are 0.

## Timing
- `busy` rises after the edge that samples `start`.
- `done` rises and `busy` falls after the edge that accepts the final bit.
- Minimum latency from the start edge to `done` is WIDTH edges (WIDTH+1 edges including the start edge).
- `done` falls after the edge that samples `ack`. The earliest next `start` is the following edge; there is no same-edge ack+start restart.
- Reset asserted mid-word clears all state and outputs immediately, without waiting for a clock edge. The partial word is discarded. After reset deasserts, the block is in IDLE.
- `busy` and `done` are registered outputs, never combinational from inputs.

## Configuration
- `SUM_OVERFLOW_EN` defined:
  - `overflow` port exists.
  - `overflow` loads `carry` on the same edge that loads `result`, and holds until the next completion or reset.
- `SUM_OVERFLOW_EN` undefined:
  - No `overflow` port, no overflow register.
  - `carry` is accepted but unused.

## Structure
- The shared package/header holds:
  - state encodings `ST_IDLE`=2'd0, `ST_COLLECT`=2'd1, `ST_DONE`=2'd2;
  - the default `WIDTH` constant.
- One sub-module: `sipo_register` — WIDTH-bit serial-in parallel-out shift register with synchronous clear, shift enable and asynchronous reset. The FSM, counter and output registers stay in `serial_sum_collector`.

## Test plan
WIDTH=8 throughout.
- Reset pulse mid-simulation → `busy`=0, `done`=0, `result`=8'h00, `overflow`=0 immediately; `start` held low for 10 cycles → no change.
- `start`, then bits of 8'hA5 LSB-first with `enable` held high → `done`=1 exactly 8 edges after the start edge, `result`=8'hA5, `busy`=0.
- `start`, then bits of 8'h3C with `enable` low every other cycle and garbage on `sum_bit` when low → `result`=8'h3C; `done` only after the 8th accepted bit (16 edges).
- `SUM_OVERFLOW_EN`, two words:
  - `carry`=1 on the final bit only → `overflow`=1.
  - `carry`=1 on bits 0–6 and 0 on bit 7 → `overflow`=0.
- Reset asserted after 4 bits of a word → outputs cleared at once. Then `start` + 8'hFF → `result`=8'hFF, `done`=1.
- In DONE, hold `ack`=0 for 5 cycles while toggling `start`/`enable`/`sum_bit` → `result` and `done` stable. Then `ack`=1 → `done`=0 next edge; `start` on the following edge → `busy`=1.
